// File: rtl/data_sram_model.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_model
// Purpose  : Behavioural data-side SRAM with a fixed-latency response pipe.
//            Requests are accepted while fewer than MAX_OUTSTANDING are in
//            flight. Each accepted transaction answers exactly LATENCY cycles
//            later, in acceptance order. Reads capture the stored word at
//            acceptance. Writes update the enabled byte lanes at the accepting
//            edge, and their response carries zero data.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-high reset (storage survives it)
//            data_req     - request valid, held until accepted
//            data_wr      - 1 = write, 0 = read
//            data_size    - 0 byte, 1 halfword, 2/3 word
//            data_addr    - byte address (upper bits alias)
//            data_wdata   - write data already in its byte lanes
//            stall        - external backpressure, blocks acceptance
//            data_rdata   - response data, zero unless data_data_ok
//            data_addr_ok - request accepted this cycle when data_req is high
//            data_data_ok - one-cycle completion pulse per transaction
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_model #(
  parameter int ADDR_WIDTH      = 12,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        stall,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam int c_depth = 1 << ADDR_WIDTH;
  localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  // The counter is loaded with LATENCY-1 at the accepting edge. It therefore
  // reads zero in cycle N+LATENCY.
  localparam logic [2:0]         c_cnt_init  = 3'(LATENCY - 1);
  localparam logic [2:0]         c_max_out   = 3'(MAX_OUTSTANDING);
  localparam logic [c_ptr_w-1:0] c_last_slot = c_ptr_w'(MAX_OUTSTANDING - 1);

  logic [31:0] mem [c_depth];

  logic [31:0]        w_q_data [MAX_OUTSTANDING];
  logic [2:0]         w_q_cnt  [MAX_OUTSTANDING];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [2:0]         r_count;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic [31:0]           w_rword;
  logic [31:0]           w_wword;
  logic                  w_accept;
  logic                  w_retire;
  logic                  w_unused;

  function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
    return (p == c_last_slot) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_idx    = data_addr[ADDR_WIDTH+1:2];
  assign w_unused = ^{data_addr[31:ADDR_WIDTH+2]};
  assign w_rword  = mem[w_idx];

  always_comb begin
    w_be = 4'b1111;
    case (data_size)
      2'd0:    w_be = 4'b0001 << data_addr[1:0];
      2'd1:    w_be = 4'b0011 << {data_addr[1], 1'b0};
      default: w_be = 4'b1111;
    endcase
  end

  // Merge the new lanes over the current word, so the array sees whole-word writes.
  always_comb begin
    w_wword = w_rword;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) begin
        w_wword[8*b +: 8] = data_wdata[8*b +: 8];
      end
    end
  end

  // Slot availability uses the registered count. A response that retires in
  // this cycle does not make room for an accept in the same cycle.
  assign data_addr_ok = !rst && !stall && (r_count < c_max_out);
  assign w_accept     = data_req && data_addr_ok;

  // The head entry answers when its countdown has reached zero. Entries
  // enter in order with equal latency, so only the head can be due.
  assign w_retire     = (r_count != 3'd0) && (w_q_cnt[r_rd_ptr] == 3'd0);
  assign data_data_ok = w_retire;
  assign data_rdata   = w_retire ? w_q_data[r_rd_ptr] : 32'd0;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept && data_wr) begin
      mem[w_idx] <= w_wword;
    end
  end

  for (genvar s = 0; s < MAX_OUTSTANDING; s++) begin : g_slot
    logic [31:0] r_data;
    logic [2:0]  r_cnt;
    logic        w_load;

    assign w_load      = w_accept && (r_wr_ptr == c_ptr_w'(s));
    assign w_q_data[s] = r_data;
    assign w_q_cnt[s]  = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= 32'd0;
        r_cnt  <= 3'd0;
      end else if (w_load) begin
        r_data <= data_wr ? 32'd0 : w_rword;
        r_cnt  <= c_cnt_init;
      end else if (r_cnt != 3'd0) begin
        r_cnt  <= r_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_retire) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_model
// Purpose  : Self-checking bench for data_sram_model (LATENCY=2,
//            MAX_OUTSTANDING=2). A negedge monitor keeps a reference memory
//            and an expected-response queue. Scenario tasks add their own
//            targeted checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_model;

  logic        clk;
  logic        rst;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        stall;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] model_mem [4096];
  logic [31:0] pre_words [8];

  data_sram_model #(
    .ADDR_WIDTH      (12),
    .LATENCY         (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .stall        (stall),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference monitor: checks the acceptance rule, response timing, order and data.
  always @(negedge clk) begin
    logic        exp_ok;
    logic [3:0]  be;
    logic [31:0] w;
    exp_t        e;
    if (rst) begin
      sb_q.delete();
      n_checks++;
      if (data_addr_ok !== 1'b0 || data_data_ok !== 1'b0 || data_rdata !== 32'd0) begin
        n_errors++;
        $display("FAIL mon_reset_outputs: addr_ok=%b data_ok=%b rdata=%h, required 0/0/0",
                 data_addr_ok, data_data_ok, data_rdata);
      end
    end else begin
      exp_ok = !stall && (sb_q.size() < 2);
      n_checks++;
      if (data_addr_ok !== exp_ok) begin
        n_errors++;
        $display("FAIL mon_addr_ok cycle %0d: got %b, required %b", cyc, data_addr_ok, exp_ok);
      end
      if (data_data_ok === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL mon_unexpected_data_ok cycle %0d: got data_ok=1, required 0", cyc);
        end else begin
          e = sb_q.pop_front();
          if (cyc !== e.due || data_rdata !== e.rdata) begin
            n_errors++;
            $display("FAIL mon_response: cycle %0d rdata %h, required cycle %0d rdata %h",
                     cyc, data_rdata, e.due, e.rdata);
          end
        end
      end else begin
        n_checks++;
        if (data_data_ok !== 1'b0 || data_rdata !== 32'd0) begin
          n_errors++;
          $display("FAIL mon_idle_outputs cycle %0d: data_ok=%b rdata=%h, required 0/0",
                   cyc, data_data_ok, data_rdata);
        end
      end
      if (data_req && data_addr_ok) begin
        if (data_wr) begin
          case (data_size)
            2'd0:    be = (data_addr[1:0] == 2'd0) ? 4'b0001 :
                          (data_addr[1:0] == 2'd1) ? 4'b0010 :
                          (data_addr[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
            2'd1:    be = data_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
          endcase
          w = model_mem[data_addr[13:2]];
          for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
          model_mem[data_addr[13:2]] = w;
          e.rdata = 32'd0;
        end else begin
          e.rdata = model_mem[data_addr[13:2]];
        end
        e.due = cyc + 2;
        sb_q.push_back(e);
        n_checks++;
        if (sb_q.size() > 2) begin
          n_errors++;
          $display("FAIL mon_outstanding: %0d in flight, required at most 2", sb_q.size());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    bit acc = 1'b0;
    data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = data_addr_ok;
      @(posedge clk);
      #1;
    end
    data_req = 1'b0;
    n_checks++;
    if (!acc) begin
      n_errors++;
      $display("FAIL issue_timeout addr %h: accepted=0, required 1", a);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(posedge clk);
      #1;
      idle = (sb_q.size() == 0);
    end
    n_checks++;
    if (!idle) begin
      n_errors++;
      $display("FAIL idle_timeout: %0d responses pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (data_addr_ok !== 1'b0 || data_data_ok !== 1'b0 || data_rdata !== 32'd0) begin
        n_errors++;
        $display("FAIL reset_values: %b/%b/%h, required 0/0/0", data_addr_ok, data_data_ok, data_rdata);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_addr_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_addr_ok: got %b, required 1", data_addr_ok);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      pre_words[i] = (i == 4) ? 32'h11223344 : (32'hA0A0A0A0 + 32'(i));
      issue(1'b1, 2'd2, 32'(i * 4), pre_words[i]);
    end
    wait_idle();
  endtask

  task automatic test_read_latency();
    issue(1'b0, 2'd2, 32'h10, 32'd0);
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b0) begin
      n_errors++;
      $display("FAIL read_early_data_ok: got %b at N+1, required 0", data_data_ok);
    end
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h11223344) begin
      n_errors++;
      $display("FAIL read_latency: data_ok=%b rdata=%h, required 1 11223344", data_data_ok, data_rdata);
    end
    wait_idle();
  endtask

  task automatic test_byte_write();
    issue(1'b1, 2'd0, 32'h13, 32'hAB000000);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'd0) begin
      n_errors++;
      $display("FAIL byte_write_resp: data_ok=%b rdata=%h, required 1 00000000", data_data_ok, data_rdata);
    end
    issue(1'b0, 2'd2, 32'h10, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hAB223344) begin
      n_errors++;
      $display("FAIL byte_write_read: data_ok=%b rdata=%h, required 1 ab223344", data_data_ok, data_rdata);
    end
    wait_idle();
  endtask

  task automatic test_half_write();
    issue(1'b1, 2'd2, 32'h10, 32'h00000000);
    issue(1'b1, 2'd1, 32'h13, 32'hBEEF0000);
    issue(1'b0, 2'd2, 32'h10, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hBEEF0000) begin
      n_errors++;
      $display("FAIL half_write_hi: data_ok=%b rdata=%h, required 1 beef0000", data_data_ok, data_rdata);
    end
    issue(1'b1, 2'd1, 32'h11, 32'h0000CAFE);
    issue(1'b0, 2'd2, 32'h10, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hBEEFCAFE) begin
      n_errors++;
      $display("FAIL half_write_lo: data_ok=%b rdata=%h, required 1 beefcafe", data_data_ok, data_rdata);
    end
    // Size 3 acts as a full word, and the read uses an aliased address.
    issue(1'b1, 2'd3, 32'h12, 32'h12345678);
    issue(1'b0, 2'd2, 32'h00004010, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h12345678) begin
      n_errors++;
      $display("FAIL word3_alias_read: data_ok=%b rdata=%h, required 1 12345678", data_data_ok, data_rdata);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bit exp_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit acc;
    int n_acc = 0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = data_addr_ok;
      n_checks++;
      if (acc !== exp_pat[i]) begin
        n_errors++;
        $display("FAIL b2b_addr_ok step %0d: got %b, required %b", i, acc, exp_pat[i]);
      end
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        data_addr = data_addr + 32'd4;
      end
    end
    data_req = 1'b0;
    n_checks++;
    if (n_acc != 4) begin
      n_errors++;
      $display("FAIL b2b_accept_count: got %0d, required 4", n_acc);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit acc0, acc1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
    @(negedge clk); acc0 = data_addr_ok;
    @(posedge clk); #1 data_addr = 32'h4;
    @(negedge clk); acc1 = data_addr_ok;
    #1 rst = 1'b1; data_req = 1'b0;
    n_checks++;
    if (!(acc0 && acc1)) begin
      n_errors++;
      $display("FAIL midreset_setup: accepts %b%b, required 11", acc0, acc1);
    end
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_addr_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_addr_ok: got %b, required 1", data_addr_ok);
    end
    repeat (4) begin
      n_checks++;
      if (data_data_ok !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_stray_data_ok: got %b, required 0", data_data_ok);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue(1'b0, 2'd2, 32'h4, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== pre_words[1]) begin
      n_errors++;
      $display("FAIL midreset_mem_kept: data_ok=%b rdata=%h, required 1 %h", data_data_ok, data_rdata, pre_words[1]);
    end
    wait_idle();
  endtask

  task automatic test_stall();
    stall = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (data_addr_ok !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_addr_ok: got %b, required 0", data_addr_ok);
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_addr_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release_accept: got %b, required 1", data_addr_ok);
    end
    @(posedge clk); #1 data_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_early_data_ok: got %b, required 0", data_data_ok);
    end
    @(negedge clk);
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== pre_words[2]) begin
      n_errors++;
      $display("FAIL stall_response: data_ok=%b rdata=%h, required 1 %h", data_data_ok, data_rdata, pre_words[2]);
    end
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = 32'd0; data_wdata = 32'd0; stall = 1'b0;
    test_reset();
    @(posedge clk); #1;
    preload();
    test_read_latency();
    test_byte_write();
    test_half_write();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
